// File: rtl/method_port_driver.sv
// -----------------------------------------------------------------------------
// method_port_driver
//
// Initiator for blocks that expose a start/result/check method-port interface.
// Once started by a go pulse, it runs num_txn transactions with no external
// stimulus. Each transaction does the following:
//   - drives two LFSR-generated operands on start;
//   - waits for the result and compares it against a+b+(a^b) mod 2^W;
//   - hands the sampled result back through check and expects (result ^ d) = 0.
// Every mismatch adds one to a saturating error counter.
//
// Optional feature macro: METHOD_DRV_WATCHDOG_EN
//   When defined, each wait on an RDY_* input is bounded by TIMEOUT cycles.
//   An expired wait sets the sticky timed_out flag, counts one error and ends
//   the run. When undefined, timed_out is tied low and waits are unbounded.
//
// Parameters
//   W        operand/result width (LFSR tap table covers 2..16, 24, 32)
//   CW       transaction and error counter width
//   TIMEOUT  watchdog limit in cycles (present only with the macro defined)
//   SEED     LFSR seed; the low W bits are used and a zero seed becomes 1
//
// Ports
//   CLK, RST            clock, asynchronous active-high reset
//   go, num_txn         run request and transaction count (0 = finish at once)
//   start_a, start_b    start method arguments; EN_start qualified by RDY_start
//   result_c, result    result method argument and returned value, RDY_result
//   check_d, check      check method argument and returned value;
//                       EN_check qualified by RDY_check
//   busy, done          run in progress / one-cycle end-of-run pulse
//   err_count           mismatches in the last run (saturating)
//   timed_out           sticky watchdog flag
// -----------------------------------------------------------------------------
module method_port_driver #(
   parameter int W = 8,
   parameter int CW = 16,
`ifdef METHOD_DRV_WATCHDOG_EN
   parameter int TIMEOUT = 255,
`endif
   parameter logic [W-1:0] SEED = W'(8'hA5)
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          go,
   input  logic [CW-1:0] num_txn,
   output logic [W-1:0]  start_a,
   output logic [W-1:0]  start_b,
   input  logic          RDY_start,
   output logic          EN_start,
   output logic [W-1:0]  result_c,
   input  logic [W-1:0]  result,
   input  logic          RDY_result,
   output logic [W-1:0]  check_d,
   input  logic          RDY_check,
   output logic          EN_check,
   input  logic [W-1:0]  check,
   output logic          busy,
   output logic          done,
   output logic [CW-1:0] err_count,
   output logic          timed_out
);

   typedef enum logic [2:0] {
      IDLE,
      START,
      RES,
      CHK,
      NEXT,
      FIN
   } state_t;

   // Tap masks for a left-shifting Fibonacci LFSR. Bit t-1 is set for each
   // polynomial tap t. Every listed set gives a maximal-length sequence, so
   // the register never reaches zero from a non-zero seed.
   function automatic logic [W-1:0] tapMask();
      logic [31:0] m;
      case (W)
         2:       m = 32'h0000_0003;
         3:       m = 32'h0000_0006;
         4:       m = 32'h0000_000C;
         5:       m = 32'h0000_0014;
         6:       m = 32'h0000_0030;
         7:       m = 32'h0000_0060;
         8:       m = 32'h0000_00B8;
         9:       m = 32'h0000_0110;
         10:      m = 32'h0000_0240;
         11:      m = 32'h0000_0500;
         12:      m = 32'h0000_0829;
         13:      m = 32'h0000_100D;
         14:      m = 32'h0000_2015;
         15:      m = 32'h0000_6000;
         16:      m = 32'h0000_D008;
         24:      m = 32'h00E1_0000;
         32:      m = 32'h8020_0003;
         default: m = 32'h0000_0003 << (W - 2);
      endcase
      return m[W-1:0];
   endfunction

   localparam logic [W-1:0] Taps     = tapMask();
   localparam logic [W-1:0] SeedInit = (SEED == '0) ? W'(1) : SEED;

   // One LFSR step: shift left and feed back the parity of the tapped bits.
   function automatic logic [W-1:0] lfsrStep(input logic [W-1:0] s);
      return {s[W-2:0], ^(s & Taps)};
   endfunction

   state_t        state;
   state_t        nextState;
   logic [W-1:0]  lfsr;
   logic [W-1:0]  lfsrNext;
   logic [CW-1:0] txnCnt;
   logic [W-1:0]  regA;
   logic [W-1:0]  regB;
   logic [W-1:0]  resSample;
   logic [CW-1:0] errCnt;
   logic [W-1:0]  expResult;
   logic [W-1:0]  expCheck;
   logic          resMiss;
   logic          chkMiss;
   logic          bumpErr;
   logic          wdFire;

   assign lfsrNext  = lfsrStep(lfsr);
   assign err_count = errCnt;

`ifdef METHOD_DRV_WATCHDOG_EN
   localparam int TW = $clog2(TIMEOUT + 1);

   logic [TW-1:0] wdCnt;
   logic          timedOut;
   logic          waiting;

   // The watchdog only runs in the three states that wait on an RDY_* input.
   // It fires on the TIMEOUT-th consecutive cycle of waiting.
   always_comb begin
      waiting = ((state == START) && !RDY_start)  ||
                ((state == RES)   && !RDY_result) ||
                ((state == CHK)   && !RDY_check);
   end

   assign wdFire    = waiting && (wdCnt == TW'(TIMEOUT - 1));
   assign timed_out = timedOut;

   // The counter restarts after every handshake or state change. The sticky
   // flag is cleared only by reset or by the go that launches the next run.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         wdCnt    <= '0;
         timedOut <= 1'b0;
      end else begin
         if (waiting && !wdFire) begin
            wdCnt <= wdCnt + TW'(1);
         end else begin
            wdCnt <= '0;
         end
         if (wdFire) begin
            timedOut <= 1'b1;
         end else if ((state == IDLE) && go) begin
            timedOut <= 1'b0;
         end
      end
   end
`else
   assign wdFire    = 1'b0;
   assign timed_out = 1'b0;
`endif

   // State register. Reset is asynchronous, so the EN_* strobes (decoded from
   // state below) fall as soon as RST rises.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Next-state and method-port outputs. Arguments are driven only in their
   // own state, and each EN_* is the matching RDY_* gated by that state. This
   // way, a strobe can never appear outside its phase or without ready.
   always_comb begin
      nextState = state;
      start_a   = '0;
      start_b   = '0;
      EN_start  = 1'b0;
      result_c  = '0;
      check_d   = '0;
      EN_check  = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (go) begin
               nextState = (num_txn != '0) ? START : FIN;
            end
         end
         START: begin
            busy     = 1'b1;
            start_a  = lfsr;
            start_b  = lfsrNext;
            EN_start = RDY_start;
            if (RDY_start) begin
               nextState = RES;
            end else if (wdFire) begin
               nextState = FIN;
            end
         end
         RES: begin
            busy     = 1'b1;
            result_c = regA ^ regB;
            if (RDY_result) begin
               nextState = CHK;
            end else if (wdFire) begin
               nextState = FIN;
            end
         end
         CHK: begin
            busy     = 1'b1;
            check_d  = resSample;
            EN_check = RDY_check;
            if (RDY_check) begin
               nextState = NEXT;
            end else if (wdFire) begin
               nextState = FIN;
            end
         end
         NEXT: begin
            busy      = 1'b1;
            nextState = (txnCnt == CW'(1)) ? FIN : START;
         end
         FIN: begin
            done      = 1'b1;
            nextState = IDLE;
         end
         default: begin
            nextState = IDLE;
         end
      endcase
   end

   // Golden model. The result must equal a+b+c with c = a^b. The check
   // method is handed back the sampled result, so a correct block returns
   // result ^ d, which is zero.
   always_comb begin
      expResult = regA + regB + (regA ^ regB);
      expCheck  = resSample ^ check_d;
      resMiss   = (state == RES) && RDY_result && (result != expResult);
      chkMiss   = (state == CHK) && RDY_check && (check != expCheck);
      bumpErr   = resMiss || chkMiss || wdFire;
   end

   // Transaction datapath. The operands are latched at the start handshake,
   // so result_c stays stable while the result is outstanding. The LFSR moves
   // two steps per transaction, so consecutive operand pairs never overlap.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         lfsr      <= SeedInit;
         txnCnt    <= '0;
         regA      <= '0;
         regB      <= '0;
         resSample <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (go) begin
                  txnCnt <= num_txn;
               end
            end
            START: begin
               if (RDY_start) begin
                  regA <= lfsr;
                  regB <= lfsrNext;
               end
            end
            RES: begin
               if (RDY_result) begin
                  resSample <= result;
               end
            end
            NEXT: begin
               lfsr   <= lfsrStep(lfsrNext);
               txnCnt <= txnCnt - CW'(1);
            end
            default: begin
            end
         endcase
      end
   end

   // Error counter. It is cleared by the go that starts a run, including a
   // zero-length run. At most one event can occur per cycle, because a
   // mismatch needs ready and the watchdog needs its absence. The counter
   // stops at all-ones instead of wrapping.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         errCnt <= '0;
      end else if ((state == IDLE) && go) begin
         errCnt <= '0;
      end else if (bumpErr && (errCnt != '1)) begin
         errCnt <= errCnt + CW'(1);
      end
   end

endmodule
